// File: rtl/ss_spread_transmitter.sv
// Spread-spectrum BPSK test transmitter: DDS carrier x PRN chip (optionally x data) -> signed DAC samples.
// Register-mapped on the FE00xxxx CPU bus; three-stage sample pipeline behind a tick divider.
`timescale 1ns/1ps

module ss_spread_transmitter #(
   parameter logic [31:0] BASE_ADDR  = 32'hFE000900,
   parameter int unsigned SAMPLE_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] Wdata,
   input  logic        write,
   output logic [31:0] Rdata,
   input  logic        read,
   output logic [15:0] DAC,
   output logic        PushDAC,
   output logic        EpochSeen
);

   localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   localparam logic [31:0] OFF_CONTROL      = 32'h00;
   localparam logic [31:0] OFF_FREQ_ADD     = 32'h04;
   localparam logic [31:0] OFF_FREQ_PHASE   = 32'h08;
   localparam logic [31:0] OFF_CHIP_FREQ    = 32'h0C;
   localparam logic [31:0] OFF_CHIP_PHASE   = 32'h10;
   localparam logic [31:0] OFF_PRN          = 32'h14;
   localparam logic [31:0] OFF_DATA         = 32'h18;
   localparam logic [31:0] OFF_AMPLITUDE    = 32'h1C;
   localparam logic [31:0] OFF_SAMPLE_COUNT = 32'h20;
   localparam logic [31:0] OFF_EPOCH_COUNT  = 32'h24;
   localparam logic [31:0] OFF_STATUS       = 32'h28;

   // Quarter-wave sine, 0..32767: cubic 1.5x - 0.5x^3 with x = v/8192, top entry forced to full scale
   function automatic logic [15:0] sine_quarter(input logic [12:0] v);
      logic [13:0] x;
      logic [41:0] cube;
      logic [16:0] y;
      x    = {1'b0, v} + 14'(v[12]);
      cube = 42'(x) * 42'(x) * 42'(x);
      y    = 17'(x) * 17'd6 - 17'(cube >> 25);
      return (y > 17'd32767) ? 16'h7FFF : y[15:0];
   endfunction

   // Register file
   logic        run_q, data_en_q;
   logic [31:0] freq_add_q, freq_phase_q, chip_freq_q, chip_phase_q;
   logic [3:0]  hob_q;
   logic [13:0] poly_q, lfsr_q;
   logic [31:0] data_q;
   logic [15:0] amp_q;
   logic [31:0] sample_count_q, epoch_count_q;
   logic        status_q;
   logic [DIV_W-1:0] div_q;

   // Pipeline
   logic               s0_valid, s0_quad1, s0_chip;
   logic [12:0]        s0_v;
   logic               s1_valid;
   logic signed [16:0] s1_s;

   logic [31:0] off;
   logic        tick;
   logic        wr_control, wr_freq_add, wr_freq_phase, wr_chip_freq, wr_chip_phase;
   logic        wr_prn, wr_data, wr_amp, wr_sample_count, rd_status;
   logic [1:0]  quad;
   logic [12:0] v_sel;
   logic        ob, chip;
   logic [31:0] freq_phase_nx, chip_phase_nx;
   logic        step, epoch;
   logic [13:0] cleared, lfsr_step;
   logic [15:0] sv;
   logic [16:0] mag, s_nx;
   logic signed [33:0] prod;

   assign off  = addr - BASE_ADDR;
   assign tick = run_q && (div_q == DIV_LAST);

   assign wr_control      = write && (off == OFF_CONTROL);
   assign wr_freq_add     = write && (off == OFF_FREQ_ADD);
   assign wr_freq_phase   = write && (off == OFF_FREQ_PHASE);
   assign wr_chip_freq    = write && (off == OFF_CHIP_FREQ);
   assign wr_chip_phase   = write && (off == OFF_CHIP_PHASE);
   assign wr_prn          = write && (off == OFF_PRN);
   assign wr_data         = write && (off == OFF_DATA);
   assign wr_amp          = write && (off == OFF_AMPLITUDE);
   assign wr_sample_count = write && (off == OFF_SAMPLE_COUNT);
   assign rd_status       = read  && (off == OFF_STATUS);

   // Stage 0: phase split and chip selection from pre-update register values
   assign quad  = freq_phase_q[31:30];
   assign v_sel = quad[0] ? ~freq_phase_q[29:17] : freq_phase_q[29:17];
   assign ob    = |(lfsr_q & (14'h0001 << hob_q));
   assign chip  = ob ^ (data_en_q & data_q[0]);

   assign freq_phase_nx = freq_phase_q + freq_add_q;
   assign chip_phase_nx = chip_phase_q + chip_freq_q;

   // LFSR advances on the rising crossing of CHIP_PHASE[31]; hob bit is taken out before the shift
   assign step      = tick && !chip_phase_q[31] && chip_phase_nx[31];
   assign cleared   = lfsr_q & ~(14'h0001 << hob_q);
   assign lfsr_step = (cleared << 1) ^ (ob ? poly_q : 14'h0000);
   assign epoch     = step && (lfsr_step == 14'h0001);

   // Stage 1: quadrant sign and chip sign collapse into a single negate
   assign sv   = sine_quarter(s0_v);
   assign mag  = {1'b0, sv};
   assign s_nx = (s0_quad1 ^ s0_chip) ? (17'd0 - mag) : mag;

   // Stage 2: amplitude scaling
   assign prod = 34'(s1_s) * 34'($signed({1'b0, amp_q}));

   assign EpochSeen = status_q;

   always_comb begin
      Rdata = '0;
      if (read) begin
         case (off)
            OFF_CONTROL:      Rdata = {30'd0, data_en_q, run_q};
            OFF_FREQ_ADD:     Rdata = freq_add_q;
            OFF_FREQ_PHASE:   Rdata = freq_phase_q;
            OFF_CHIP_FREQ:    Rdata = chip_freq_q;
            OFF_CHIP_PHASE:   Rdata = chip_phase_q;
            OFF_PRN:          Rdata = {hob_q, poly_q, lfsr_q};
            OFF_DATA:         Rdata = data_q;
            OFF_AMPLITUDE:    Rdata = {16'd0, amp_q};
            OFF_SAMPLE_COUNT: Rdata = sample_count_q;
            OFF_EPOCH_COUNT:  Rdata = epoch_count_q;
            OFF_STATUS:       Rdata = {31'd0, status_q};
            default:          Rdata = '0;
         endcase
      end
   end

   // Registers: a bus write in a tick cycle takes priority over that register's tick update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q          <= 1'b0;
         data_en_q      <= 1'b0;
         freq_add_q     <= '0;
         freq_phase_q   <= '0;
         chip_freq_q    <= '0;
         chip_phase_q   <= '0;
         hob_q          <= '0;
         poly_q         <= '0;
         lfsr_q         <= '0;
         data_q         <= '0;
         amp_q          <= '0;
         sample_count_q <= '0;
         epoch_count_q  <= '0;
         status_q       <= 1'b0;
         div_q          <= '0;
      end else begin
         if (!run_q || div_q == DIV_LAST) div_q <= '0;
         else                             div_q <= div_q + DIV_W'(1);

         if (wr_control) {data_en_q, run_q} <= Wdata[1:0];
         if (wr_freq_add)  freq_add_q  <= Wdata;
         if (wr_chip_freq) chip_freq_q <= Wdata;
         if (wr_amp)       amp_q       <= Wdata[15:0];

         if (wr_freq_phase) freq_phase_q <= Wdata;
         else if (tick)     freq_phase_q <= freq_phase_nx;

         if (wr_chip_phase) chip_phase_q <= Wdata;
         else if (tick)     chip_phase_q <= chip_phase_nx;

         if (wr_sample_count) sample_count_q <= Wdata;
         else if (tick)       sample_count_q <= sample_count_q + 32'd1;

         if (wr_prn) begin
            hob_q  <= Wdata[31:28];
            poly_q <= Wdata[27:14];
            lfsr_q <= Wdata[13:0];
         end else if (step) begin
            lfsr_q <= lfsr_step;
         end

         if (wr_data)    data_q <= Wdata;
         else if (epoch) data_q <= data_q >> 1;

         if (epoch) epoch_count_q <= epoch_count_q + 32'd1;

         if (epoch)          status_q <= 1'b1;
         else if (rd_status) status_q <= 1'b0;
      end
   end

   // Sample pipeline: tick -> PushDAC is three clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_quad1 <= 1'b0;
         s0_chip  <= 1'b0;
         s0_v     <= '0;
         s1_valid <= 1'b0;
         s1_s     <= '0;
         PushDAC  <= 1'b0;
         DAC      <= '0;
      end else begin
         s0_valid <= tick;
         if (tick) begin
            s0_quad1 <= quad[1];
            s0_chip  <= chip;
            s0_v     <= v_sel;
         end
         s1_valid <= s0_valid;
         if (s0_valid) s1_s <= s_nx;
         PushDAC <= s1_valid;
         if (s1_valid) DAC <= 16'(prod >>> 16);
      end
   end

endmodule

// File: tb/tb_ss_spread_transmitter.sv
// Scoreboard bench for ss_spread_transmitter: stimulus queues expected DAC pushes and read data,
// a negedge monitor pops and compares whenever PushDAC or read is seen.
`timescale 1ns/1ps

module tb_ss_spread_transmitter;

   localparam logic [31:0] BASE           = 32'hFE000900;
   localparam logic [31:0] A_CONTROL      = BASE + 32'h00;
   localparam logic [31:0] A_FREQ_ADD     = BASE + 32'h04;
   localparam logic [31:0] A_FREQ_PHASE   = BASE + 32'h08;
   localparam logic [31:0] A_CHIP_FREQ    = BASE + 32'h0C;
   localparam logic [31:0] A_CHIP_PHASE   = BASE + 32'h10;
   localparam logic [31:0] A_PRN          = BASE + 32'h14;
   localparam logic [31:0] A_DATA         = BASE + 32'h18;
   localparam logic [31:0] A_AMPLITUDE    = BASE + 32'h1C;
   localparam logic [31:0] A_SAMPLE_COUNT = BASE + 32'h20;
   localparam logic [31:0] A_EPOCH_COUNT  = BASE + 32'h24;
   localparam logic [31:0] A_STATUS       = BASE + 32'h28;

   // sv(1FFF)=32767 at amplitude FFFF: (32767*65535)>>16 = 7FFE, negated = -32767 = 8001
   localparam logic [15:0] POS  = 16'h7FFE;
   localparam logic [15:0] NEG  = 16'h8001;
   localparam logic [15:0] ZERO = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, Wdata, Rdata;
   logic        write, read;
   logic [15:0] DAC;
   logic        PushDAC, EpochSeen;

   ss_spread_transmitter #(.BASE_ADDR(BASE), .SAMPLE_DIV(1)) dut (
      .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
      .Rdata(Rdata), .read(read), .DAC(DAC), .PushDAC(PushDAC), .EpochSeen(EpochSeen)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed { logic [15:0] dac; logic [31:0] cyc; } push_t;
   typedef struct { logic [31:0] val; string name; } rd_t;

   push_t       sb[$];
   rd_t         rd_q[$];
   logic [15:0] plan_q[$];
   push_t       mon_e;
   rd_t         mon_r;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   // LFSR values for hob=3, poly=3 starting from 1 (period 15)
   logic [3:0] seq [0:14] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                              4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (PushDAC) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_push: DAC=%04h at cycle %0d, required no push", DAC, cyc);
            end else begin
               mon_e = sb.pop_front();
               check("dac", {16'd0, DAC}, {16'd0, mon_e.dac});
               check("push_cycle", cyc, mon_e.cyc);
            end
         end
         if (read) begin
            if (rd_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unplanned_read: Rdata=%08h at cycle %0d", Rdata, cyc);
            end else begin
               mon_r = rd_q.pop_front();
               check(mon_r.name, Rdata, mon_r.val);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; Wdata = d; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      rd_t r;
      r.val = exp; r.name = name;
      rd_q.push_back(r);
      addr = a; read = 1'b1;
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   // Expected samples for n ticks of the PRN test: chip = value[3] ^ (data bit for ticks <= neg_upto)
   task automatic plan_prn(input int n, input int neg_upto);
      for (int k = 1; k <= n; k++) begin
         logic [3:0] val;
         logic       c;
         val = seq[(k / 2) % 15];
         c   = val[3] ^ (k <= neg_upto);
         plan_q.push_back(c ? NEG : POS);
      end
   endtask

   // Run exactly plan_q.size() ticks; optional bus op issued in the cycle of tick op_tick
   task automatic run_ticks(input logic [1:0] ctrl, input int op_tick, input bit op_wr,
                            input logic [31:0] op_a, input logic [31:0] op_d, input string op_name);
      int          n;
      int unsigned c0;
      push_t       e;
      n  = plan_q.size();
      c0 = cyc;
      for (int k = 1; k <= n; k++) begin
         e.dac = plan_q[k-1];
         e.cyc = 32'(c0 + k + 3);
         sb.push_back(e);
      end
      plan_q.delete();
      wr(A_CONTROL, {30'd0, ctrl});
      for (int k = 1; k < n; k++) begin
         if (k == op_tick) begin
            if (op_wr) wr(op_a, op_d);
            else       rd(op_a, op_d, op_name);
         end else begin
            idle(1);
         end
      end
      wr(A_CONTROL, {30'd0, ctrl & 2'b10});
      idle(5);
   endtask

   initial begin
      rst = 1'b1; addr = '0; Wdata = '0; write = 1'b0; read = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("init_dac", {16'd0, DAC}, 32'd0);
      check("init_push", {31'd0, PushDAC}, 32'd0);

      // Reset mid-run
      wr(A_AMPLITUDE, 32'h0000_FFFF);
      wr(A_FREQ_PHASE, 32'h3FFE_0000);
      wr(A_CONTROL, 32'h1);
      idle(6);
      #2 rst = 1'b1;
      #1;
      check("rst_dac", {16'd0, DAC}, 32'd0);
      check("rst_push", {31'd0, PushDAC}, 32'd0);
      check("rst_epochseen", {31'd0, EpochSeen}, 32'd0);
      addr = A_AMPLITUDE; read = 1'b1;
      #1 check("rst_rd_amplitude", Rdata, 32'd0);
      addr = A_FREQ_PHASE;
      #1 check("rst_rd_freq_phase", Rdata, 32'd0);
      read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      rd(A_CONTROL, 32'd0, "post_rst_control");
      rd(A_SAMPLE_COUNT, 32'd0, "post_rst_sample_count");
      rd(A_PRN, 32'd0, "post_rst_prn");
      rd(A_STATUS, 32'd0, "post_rst_status");
      idle(6);

      // Quadrant walk, back-to-back pushes
      wr(A_FREQ_ADD, 32'h4000_0000);
      wr(A_AMPLITUDE, 32'h0000_FFFF);
      for (int i = 0; i < 2; i++) begin
         plan_q.push_back(ZERO); plan_q.push_back(POS);
         plan_q.push_back(ZERO); plan_q.push_back(NEG);
      end
      run_ticks(2'b01, 0, 1'b0, 32'd0, 32'd0, "");
      rd(A_SAMPLE_COUNT, 32'd8, "quad_sample_count");
      rd(A_FREQ_PHASE, 32'd0, "quad_freq_phase");

      // PRN epoch, data_en off
      wr(A_FREQ_ADD, 32'd0);
      wr(A_FREQ_PHASE, 32'h3FFE_0000);
      wr(A_CHIP_FREQ, 32'h8000_0000);
      wr(A_CHIP_PHASE, 32'd0);
      wr(A_PRN, 32'h3000_C001);
      plan_prn(30, 0);
      run_ticks(2'b01, 0, 1'b0, 32'd0, 32'd0, "");
      rd(A_PRN, 32'h3000_C001, "prn_after_epoch");
      rd(A_EPOCH_COUNT, 32'd1, "epoch_count_1");
      rd(A_SAMPLE_COUNT, 32'd38, "sample_count_38");
      check("epochseen_set", {31'd0, EpochSeen}, 32'd1);
      rd(A_STATUS, 32'd1, "status_set");
      check("epochseen_cleared", {31'd0, EpochSeen}, 32'd0);
      rd(A_STATUS, 32'd0, "status_cleared");

      // Data modulation: first epoch inverted, DATA shifted out
      wr(A_DATA, 32'h1);
      wr(A_PRN, 32'h3000_C001);
      plan_prn(60, 29);
      run_ticks(2'b11, 0, 1'b0, 32'd0, 32'd0, "");
      rd(A_DATA, 32'd0, "data_consumed");
      rd(A_EPOCH_COUNT, 32'd3, "epoch_count_3");
      rd(A_STATUS, 32'd1, "status_after_data");

      // STATUS read coinciding with an epoch: set wins
      plan_prn(30, 0);
      run_ticks(2'b01, 29, 1'b0, A_STATUS, 32'd0, "status_read_at_epoch");
      check("epochseen_set_wins", {31'd0, EpochSeen}, 32'd1);
      rd(A_STATUS, 32'd1, "status_set_wins");
      rd(A_STATUS, 32'd0, "status_clear_no_epoch");

      // Bus write beats tick update of FREQ_PHASE only
      wr(A_FREQ_ADD, 32'h0000_1000);
      wr(A_CHIP_FREQ, 32'h10);
      wr(A_SAMPLE_COUNT, 32'd0);
      plan_q.push_back(POS); plan_q.push_back(POS); plan_q.push_back(ZERO);
      run_ticks(2'b01, 2, 1'b1, A_FREQ_PHASE, 32'h8000_0000, "");
      rd(A_FREQ_PHASE, 32'h8000_1000, "freq_phase_write_wins");
      rd(A_CHIP_PHASE, 32'h30, "chip_phase_advanced");
      rd(A_SAMPLE_COUNT, 32'd3, "sample_count_advanced");

      // RO write ignored, unmapped read, read strobe low
      wr(A_EPOCH_COUNT, 32'hFF);
      rd(A_EPOCH_COUNT, 32'd4, "epoch_count_ro");
      rd(BASE + 32'h2C, 32'd0, "unmapped_read");
      addr = A_SAMPLE_COUNT; read = 1'b0;
      #1 check("rdata_idle", Rdata, 32'd0);

      idle(4);
      check("sb_drained", sb.size(), 32'd0);
      check("rdq_drained", rd_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
